// File: rtl/adc_pulse_finder.sv
// Pulse finder for a 14-bit ADC stream: tracking baseline, threshold trigger, TOT/amplitude word.
// Optional sample-count timestamp enabled by defining ADC_PULSE_FINDER_TIMESTAMP_EN.
module adc_pulse_finder #(
    parameter int unsigned TOT_WIDTH = 8,
    parameter int unsigned TS_WIDTH  = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [13:0] ADC_DATA,
    input  logic        ADC_VALID,
    input  logic        CONF_EN,
    input  logic [13:0] CONF_THRESHOLD,
    input  logic [7:0]  CONF_HOLDOFF,
    output logic [31:0] DATA_OUT,
    output logic        DATA_VALID,
    input  logic        DATA_READY,
    output logic [7:0]  LOST_CNT,
    output logic [13:0] BASELINE
);

    typedef enum logic [1:0] {StIdle, StPulse, StHoldoff} state_e;

    localparam logic [TOT_WIDTH-1:0] TotMax = '1;

    state_e                 state_q, state_d;
    logic [13:0]            bl_q, bl_d;
    logic                   bl_loaded_q, bl_loaded_d;
    logic [TOT_WIDTH-1:0]   tot_q, tot_d;
    logic [13:0]            xmax_q, xmax_d;
    logic [7:0]             hold_q, hold_d;
    logic [31:0]            dout_q, dout_d;
    logic                   dv_q, dv_d;
    logic [7:0]             lost_q, lost_d;

    logic [14:0]            level;
    logic                   above;
    logic signed [14:0]     diff;
    logic signed [14:0]     bl_upd;
    logic                   enter_pulse;
    logic                   word_done;
    logic [13:0]            ampl;
    logic [TS_WIDTH-1:0]    ts_word;

    // Trigger level kept at 15 bits so a large threshold never wraps below the sample range.
    assign level  = {1'b0, bl_q} + {1'b0, CONF_THRESHOLD};
    assign above  = {1'b0, ADC_DATA} > level;
    assign diff   = $signed({1'b0, ADC_DATA}) - $signed({1'b0, bl_q});
    assign bl_upd = $signed({1'b0, bl_q}) + (diff >>> 4);
    assign ampl   = xmax_q - bl_q;

    always_comb begin
        state_d     = state_q;
        bl_d        = bl_q;
        bl_loaded_d = bl_loaded_q;
        tot_d       = tot_q;
        xmax_d      = xmax_q;
        hold_d      = hold_q;
        enter_pulse = 1'b0;
        word_done   = 1'b0;
        if (ADC_VALID) begin
            if (!bl_loaded_q) begin
                // First sample only seeds the baseline; it cannot trigger.
                bl_d        = ADC_DATA;
                bl_loaded_d = 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (CONF_EN && above) begin
                            state_d     = StPulse;
                            tot_d       = TOT_WIDTH'(1);
                            xmax_d      = ADC_DATA;
                            enter_pulse = 1'b1;
                        end else begin
                            bl_d = 14'(bl_upd);
                        end
                    end
                    StPulse: begin
                        if (!CONF_EN) begin
                            state_d = StIdle;
                        end else if (above) begin
                            if (tot_q != TotMax) tot_d = tot_q + 1'b1;
                            if (ADC_DATA > xmax_q) xmax_d = ADC_DATA;
                        end else begin
                            state_d   = StHoldoff;
                            hold_d    = 8'd0;
                            word_done = 1'b1;
                        end
                    end
                    StHoldoff: begin
                        if (!CONF_EN || hold_q >= CONF_HOLDOFF) begin
                            state_d = StIdle;
                        end else begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        dv_d   = dv_q;
        lost_d = lost_q;
        if (word_done) begin
            // A word is only lost if the pending one is not being taken this cycle.
            if (dv_q && !DATA_READY) begin
                if (lost_q != 8'hff) lost_d = lost_q + 8'd1;
            end else begin
                dout_d = {8'(tot_q), ampl, 10'(ts_word)};
                dv_d   = 1'b1;
            end
        end else if (dv_q && DATA_READY) begin
            dv_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            bl_q        <= 14'd0;
            bl_loaded_q <= 1'b0;
            tot_q       <= '0;
            xmax_q      <= 14'd0;
            hold_q      <= 8'd0;
            dout_q      <= 32'd0;
            dv_q        <= 1'b0;
            lost_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            bl_q        <= bl_d;
            bl_loaded_q <= bl_loaded_d;
            tot_q       <= tot_d;
            xmax_q      <= xmax_d;
            hold_q      <= hold_d;
            dout_q      <= dout_d;
            dv_q        <= dv_d;
            lost_q      <= lost_d;
        end
    end

`ifdef ADC_PULSE_FINDER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [TS_WIDTH-1:0] pts_q, pts_d;

    always_comb begin
        ts_d  = ADC_VALID ? ts_q + 1'b1 : ts_q;
        pts_d = enter_pulse ? ts_q : pts_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ts_q  <= '0;
            pts_q <= '0;
        end else begin
            ts_q  <= ts_d;
            pts_q <= pts_d;
        end
    end

    assign ts_word = pts_q;
`else
    assign ts_word = '0;
`endif

    assign DATA_OUT   = dout_q;
    assign DATA_VALID = dv_q;
    assign LOST_CNT   = lost_q;
    assign BASELINE   = bl_q;

endmodule

// File: tb/tb_adc_pulse_finder.sv
// Directed, table-driven bench for adc_pulse_finder (threshold 50 over a 1030 baseline).
`timescale 1ns/1ps
module tb_adc_pulse_finder;

    logic        CLK = 1'b0;
    logic        RST;
    logic [13:0] ADC_DATA;
    logic        ADC_VALID;
    logic        CONF_EN;
    logic [13:0] CONF_THRESHOLD;
    logic [7:0]  CONF_HOLDOFF;
    logic [31:0] DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [7:0]  LOST_CNT;
    logic [13:0] BASELINE;

    adc_pulse_finder dut (
        .CLK            (CLK),
        .RST            (RST),
        .ADC_DATA       (ADC_DATA),
        .ADC_VALID      (ADC_VALID),
        .CONF_EN        (CONF_EN),
        .CONF_THRESHOLD (CONF_THRESHOLD),
        .CONF_HOLDOFF   (CONF_HOLDOFF),
        .DATA_OUT       (DATA_OUT),
        .DATA_VALID     (DATA_VALID),
        .DATA_READY     (DATA_READY),
        .LOST_CNT       (LOST_CNT),
        .BASELINE       (BASELINE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int idx = 0;

    // Accepted words, captured on the falling edge before the accepting rising edge.
    logic [31:0] words [0:63];
    logic [13:0] bls   [0:63];
    int wcnt = 0;
    int rd = 0;

    always @(negedge CLK) begin
        if (DATA_VALID === 1'b1 && DATA_READY === 1'b1 && wcnt < 64) begin
            words[wcnt] = DATA_OUT;
            bls[wcnt]   = BASELINE;
            wcnt++;
        end
    end

    typedef struct {
        logic [13:0] val;
        int          len;
        logic [13:0] thr;
        bit          has_word;
        int          tot;
        int          ampl;
    } rec_t;

    rec_t tab [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] exp_ts(input int entry);
`ifdef ADC_PULSE_FINDER_TIMESTAMP_EN
        return 10'(entry % 1024);
`else
        return 10'(entry - entry);
`endif
    endfunction

    function automatic logic [31:0] mkword(input int tot, input int ampl, input logic [9:0] ts);
        return {8'(tot), 14'(ampl), ts};
    endfunction

    task automatic smp(input logic [13:0] x);
        ADC_DATA  = x;
        ADC_VALID = 1'b1;
        @(posedge CLK);
        #1;
        idx++;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) smp(14'd1030);
    endtask

    task automatic rect(input logic [13:0] v, input int len);
        for (int i = 0; i < len; i++) smp(v);
        smp(14'd1030);
    endtask

    task automatic ramp(input int start);
        for (int v = start; v <= 1230; v += 20) smp(14'(v));
        for (int v = 1228; v >= 1030; v -= 2) smp(14'(v));
    endtask

    task automatic expect_word(input string name, input int tot, input int ampl,
                               input logic [9:0] ts, input int bl);
        checks++;
        if (rd >= wcnt) begin
            failures++;
            $display("FAIL %s_missing actual=%0d words required=%0d", name, wcnt, rd + 1);
        end else begin
            checks--;
            check(name, words[rd], mkword(tot, ampl, ts));
            check({name, "_bl"}, 32'(bls[rd]), 32'(bl));
            rd++;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        ADC_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        idx = 0;
    endtask

    int entry;
    int w0;
    int lost0;

    initial begin
        tab[0] = '{val: 14'd1081,  len: 1,  thr: 14'd50,    has_word: 1'b1, tot: 1,  ampl: 51};
        tab[1] = '{val: 14'd1080,  len: 4,  thr: 14'd50,    has_word: 1'b0, tot: 0,  ampl: 0};
        tab[2] = '{val: 14'd2000,  len: 3,  thr: 14'd50,    has_word: 1'b1, tot: 3,  ampl: 970};
        tab[3] = '{val: 14'd1500,  len: 10, thr: 14'd50,    has_word: 1'b1, tot: 10, ampl: 470};
        tab[4] = '{val: 14'd16383, len: 3,  thr: 14'd16000, has_word: 1'b0, tot: 0,  ampl: 0};
        tab[5] = '{val: 14'd16383, len: 2,  thr: 14'd15352, has_word: 1'b1, tot: 2,  ampl: 15353};

        ADC_DATA = 14'd0; CONF_EN = 1'b1; CONF_THRESHOLD = 14'd50; CONF_HOLDOFF = 8'd4;
        DATA_READY = 1'b1;
        do_reset();
        @(negedge CLK);
        check("rst_dvalid", 32'(DATA_VALID), 32'd0);
        check("rst_dout", DATA_OUT, 32'd0);
        check("rst_lost", 32'(LOST_CNT), 32'd0);
        check("rst_baseline", 32'(BASELINE), 32'd0);
        @(posedge CLK); #1;

        // Flat baseline: no trigger, baseline locks to the level.
        settle(300);
        check("bl_flat", 32'(BASELINE), 32'd1030);
        check("bl_nowords", 32'(wcnt), 32'd0);

        for (int i = 0; i < 6; i++) begin
            CONF_THRESHOLD = tab[i].thr;
            w0 = wcnt;
            entry = idx;
            rect(tab[i].val, tab[i].len);
            settle(300);
            check($sformatf("tab%0d_nwords", i), 32'(wcnt - w0), 32'(tab[i].has_word));
            if (tab[i].has_word) expect_word($sformatf("tab%0d_word", i), tab[i].tot,
                                             tab[i].ampl, exp_ts(entry), 1030);
            rd = wcnt;
        end
        CONF_THRESHOLD = 14'd50;

        // Full ramp: 1050/1070 are sub-threshold IDLE samples, so the baseline drifts
        // 1030->1031->1033 before 1090 triggers (level 1083): TOT 8+73, AMPL 1230-1033.
        entry = idx + 2;
        ramp(1050);
        settle(300);
        expect_word("ramp_full", 81, 197, exp_ts(entry), 1033);
        check("ramp_full_bl_back", 32'(BASELINE), 32'd1030);

        // Ramp starting at the first above sample: TOT 8+74, AMPL 200, baseline untouched.
        entry = idx;
        ramp(1090);
        settle(300);
        expect_word("ramp", 82, 200, exp_ts(entry), 1030);

        // Backpressure: second word dropped, first held.
        DATA_READY = 1'b0;
        entry = idx;
        ramp(1090);
        settle(50);
        ramp(1090);
        settle(50);
        @(negedge CLK);
        check("bp_dvalid", 32'(DATA_VALID), 32'd1);
        check("bp_held", DATA_OUT, mkword(82, 200, exp_ts(entry)));
        check("bp_lost", 32'(LOST_CNT), 32'd1);
        check("bp_nocapture", 32'(wcnt - rd), 32'd0);
        DATA_READY = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("bp_drained", 32'(DATA_VALID), 32'd0);
        expect_word("bp_word", 82, 200, exp_ts(entry), 1030);
        @(posedge CLK); #1;

        // Acceptance in the completing cycle frees the slot: no drop.
        DATA_READY = 1'b0;
        entry = idx;
        rect(14'd2000, 3);
        settle(20);
        lost0 = LOST_CNT;
        w0 = idx;
        smp(14'd2000);
        smp(14'd2000);
        DATA_READY = 1'b1;
        smp(14'd1030);
        settle(20);
        expect_word("same_a", 3, 970, exp_ts(entry), 1030);
        expect_word("same_b", 2, 970, exp_ts(w0), 1030);
        check("same_lost", 32'(LOST_CNT), 32'(lost0));

        // Holdoff 0: the sample after the end sample is consumed, the next one retriggers.
        CONF_HOLDOFF = 8'd0;
        smp(14'd2000);
        smp(14'd1030);
        smp(14'd1500);
        entry = idx;
        smp(14'd1600);
        smp(14'd1030);
        CONF_HOLDOFF = 8'd4;
        settle(300);
        expect_word("hold0_a", 1, 970, exp_ts(entry - 3), 1030);
        expect_word("hold0_b", 1, 570, exp_ts(entry), 1030);

        // TOT saturation.
        entry = idx;
        rect(14'd2000, 300);
        settle(300);
        expect_word("sat", 255, 970, exp_ts(entry), 1030);

        // Abort by CONF_EN at the 5th pulse sample.
        w0 = wcnt;
        lost0 = LOST_CNT;
        for (int i = 0; i < 4; i++) smp(14'd2000);
        CONF_EN = 1'b0;
        smp(14'd2000);
        settle(20);
        CONF_EN = 1'b1;
        settle(20);
        check("en_abort_nowords", 32'(wcnt - w0), 32'd0);
        check("en_abort_lost", 32'(LOST_CNT), 32'(lost0));
        entry = idx;
        rect(14'd1500, 3);
        settle(300);
        expect_word("en_after", 3, 470, exp_ts(entry), 1030);

        // Abort by reset at the 5th pulse sample.
        w0 = wcnt;
        for (int i = 0; i < 4; i++) smp(14'd2000);
        ADC_DATA = 14'd2000;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        idx = 0;
        ADC_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_abort_nowords", 32'(wcnt - w0), 32'd0);
        check("rst_abort_dvalid", 32'(DATA_VALID), 32'd0);
        check("rst_abort_lost", 32'(LOST_CNT), 32'd0);
        check("rst_abort_bl", 32'(BASELINE), 32'd0);
        @(posedge CLK); #1;

        // Timestamp wrap: entry at valid-sample index 1027.
        settle(1027);
        entry = idx;
        rect(14'd1090, 1);
        settle(20);
        check("ts_entry_idx", 32'(entry), 32'd1027);
        expect_word("ts_wrap", 1, 60, exp_ts(1027), 1030);

        ADC_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
